// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if
//   Bundles the command channel, the response channel and the APB segment of
//   apb_cmd_master. Clock and reset stay outside as plain ports.
//
//   master modport : the command master (drives APB, returns responses)
//   slave  modport : the surrounding world (issues commands, models slaves)
//
//   cmd_*   : valid/ready command stream (write, address, data, strobes)
//   rsp_*   : valid/ready response stream (read data, error, timeout flag)
//   psel..  : APB4 request signals, one-hot psel over NUM_SLV slaves
//   prdata  : packed per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pready  : per-slave ready
//   pslverr : per-slave error
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0]         cmd_wdata;
  logic [STRB_WIDTH-1:0]         cmd_strb;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          rsp_timeout;

  logic [NUM_SLV-1:0]            psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [STRB_WIDTH-1:0]         pstrb;
  logic [NUM_SLV*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLV-1:0]            pready;
  logic [NUM_SLV-1:0]            pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB4 master turning a valid/ready command stream into single APB
//   transfers. The slave is picked by the top SEL_BITS address bits; an
//   index with no slave behind it is answered at once with an error and no
//   APB activity. ACCESS is bounded by TIMEOUT wait cycles (0 = unbounded).
//
//   Ports:
//     pclk    : clock
//     presetn : asynchronous active-low reset, forces every output to 0
//     bus     : apb_cmd_master_if.master (command, response and APB signals)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | APB setup phase: psel high, penable low (one cycle)
//   ACCESS | APB access phase: psel and penable high until pready/timeout
//   RESP   | rsp_valid high, response held until rsp_ready
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_cmd_master_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_BITS   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TO_LAST_I);
  localparam logic [SEL_BITS:0] NUM_SLV_W  = (SEL_BITS + 1)'(NUM_SLV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  // registered outputs and internal state
  logic                  cmd_ready_q,   cmd_ready_nxt;
  logic                  rsp_valid_q,   rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_nxt;
  logic                  rsp_err_q,     rsp_err_nxt;
  logic                  rsp_timeout_q, rsp_timeout_nxt;
  logic [NUM_SLV-1:0]    psel_q,        psel_nxt;
  logic                  penable_q,     penable_nxt;
  logic                  pwrite_q,      pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_nxt;
  logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_nxt;
  logic [SEL_BITS-1:0]   idx_q,         idx_nxt;
  logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_nxt;

  logic                  cmd_fire;
  logic                  rsp_fire;
  logic [SEL_BITS-1:0]   cmd_idx;
  logic                  decode_ok;
  logic                  sel_pready;
  logic                  sel_pslverr;
  logic [DATA_WIDTH-1:0] sel_prdata;
  logic                  timeout_hit;

  assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
  assign rsp_fire  = rsp_valid_q & bus.rsp_ready;
  assign cmd_idx   = bus.cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign decode_ok = ({1'b0, cmd_idx} < NUM_SLV_W);

  // Only the latched slave is looked at; everything else on the APB return
  // path is ignored, including the selected slave's pready during SETUP
  // (the FSM only consults sel_pready in ACCESS).
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_pready  = bus.pready[i];
        sel_pslverr = bus.pslverr[i];
        sel_prdata  = bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The counter holds the number of pready-low ACCESS cycles already spent;
  // the abort fires on the TIMEOUT-th such cycle so ACCESS lasts exactly
  // TIMEOUT cycles when the slave never answers.
  assign timeout_hit = (TIMEOUT > 0) && !sel_pready && (wait_cnt_q == TO_LAST);

  // state and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_nxt;
      cmd_ready_q   <= cmd_ready_nxt;
      rsp_valid_q   <= rsp_valid_nxt;
      rsp_rdata_q   <= rsp_rdata_nxt;
      rsp_err_q     <= rsp_err_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
      psel_q        <= psel_nxt;
      penable_q     <= penable_nxt;
      pwrite_q      <= pwrite_nxt;
      paddr_q       <= paddr_nxt;
      pwdata_q      <= pwdata_nxt;
      pstrb_q       <= pstrb_nxt;
      idx_q         <= idx_nxt;
      wait_cnt_q    <= wait_cnt_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) state_nxt = decode_ok ? S_SETUP : S_RESP;
      end
      S_SETUP: begin
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_pready || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed for the coming cycle from the transition being
  // taken, so every output leaves a flop and lines up with state_q.
  always_comb begin
    idx_nxt         = idx_q;
    wait_cnt_nxt    = wait_cnt_q;
    pwrite_nxt      = pwrite_q;
    paddr_nxt       = paddr_q;
    pwdata_nxt      = pwdata_q;
    pstrb_nxt       = pstrb_q;
    rsp_rdata_nxt   = rsp_rdata_q;
    rsp_err_nxt     = rsp_err_q;
    rsp_timeout_nxt = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          idx_nxt         = cmd_idx;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = !decode_ok;
          rsp_timeout_nxt = 1'b0;
          // A decode error leaves the APB request lines untouched.
          if (decode_ok) begin
            wait_cnt_nxt = '0;
            pwrite_nxt   = bus.cmd_write;
            paddr_nxt    = bus.cmd_addr;
            pwdata_nxt   = bus.cmd_wdata;
            pstrb_nxt    = bus.cmd_write ? bus.cmd_strb : '0;
          end
        end
      end
      S_ACCESS: begin
        if (sel_pready) begin
          rsp_rdata_nxt   = (!pwrite_q && !sel_pslverr) ? sel_prdata : '0;
          rsp_err_nxt     = sel_pslverr;
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
        end
      end
      default: ;
    endcase

    cmd_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_RESP);
    penable_nxt   = (state_nxt == S_ACCESS);
    psel_nxt      = '0;
    if (state_nxt == S_SETUP || state_nxt == S_ACCESS) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        psel_nxt[i] = (idx_nxt == SEL_BITS'(i));
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
//   Random and directed commands against apb_cmd_master (NUM_SLV=3 so the
//   top index 3 exercises the decode error). A per-transaction model derives
//   the expected SETUP/ACCESS lengths, response latency and response fields
//   from the command and the slave's programmed wait count.
module tb_apb_cmd_master;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_SLV    = 3;
  localparam int TIMEOUT    = 16;

  logic pclk = 1'b0;
  logic presetn;
  int   n_vec = 0;
  int   n_err = 0;

  apb_cmd_master_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_SLV(NUM_SLV)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
             bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb};
  endfunction

  // One command end to end. wt = pready-low ACCESS cycles the slave inserts
  // (large values mean it never answers); hold = cycles rsp_ready stays low.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int wt, input logic perr,
                         input logic [31:0] rd, input int hold);
    int idx, exp_setup, exp_acc, exp_lat;
    logic exp_err, exp_to;
    logic [31:0] exp_rd;
    logic [NUM_SLV-1:0] exp_sel;
    int c, n_setup, n_acc, lat, acc_k, viol, hviol, budget;

    // reference model
    idx = int'(addr[31:30]);
    exp_sel = '0;
    if (idx >= NUM_SLV) begin
      exp_setup = 0; exp_acc = 0;
      exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
    end else begin
      exp_sel[idx] = 1'b1;
      exp_setup = 1;
      if (TIMEOUT > 0 && wt >= TIMEOUT) begin
        exp_acc = TIMEOUT; exp_err = 1'b1; exp_to = 1'b1; exp_rd = '0;
      end else begin
        exp_acc = wt + 1; exp_err = perr; exp_to = 1'b0;
        exp_rd = (wr || perr) ? 32'h0 : rd;
      end
    end
    exp_lat = 1 + exp_setup + exp_acc;

    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wd;   bus.cmd_strb = st;
    bus.rsp_ready = (hold == 0);
    budget = 0;
    while (!bus.cmd_ready && budget < 20) begin
      @(negedge pclk);
      budget++;
    end
    chk("cmd_accept", 64'(budget < 20), 64'(1));

    c = 0; n_setup = 0; n_acc = 0; lat = -1; acc_k = 0; viol = 0;
    while (lat < 0 && c < 60) begin
      @(negedge pclk);
      c++;
      bus.cmd_valid = 1'b0;
      if (bus.cmd_ready) viol++;
      if (bus.rsp_valid) begin
        lat = c;
      end else begin
        if (bus.penable && bus.psel == '0) viol++;
        if (!$onehot0(bus.psel)) viol++;
        if (bus.psel != '0) begin
          if (bus.psel != exp_sel) viol++;
          if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wd ||
              bus.pstrb !== (wr ? st : 4'h0)) viol++;
          if (bus.penable) n_acc++; else n_setup++;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
          bus.pready[i]  = 1'($urandom);
          bus.pslverr[i] = 1'($urandom);
          bus.prdata[i*DATA_WIDTH +: DATA_WIDTH] = $urandom;
        end
        if (bus.penable && idx < NUM_SLV) begin
          bus.pready[idx]  = (acc_k == wt);
          bus.pslverr[idx] = perr;
          bus.prdata[idx*DATA_WIDTH +: DATA_WIDTH] = rd;
          acc_k++;
        end
      end
    end
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("setup_cycles", 64'(n_setup), 64'(exp_setup));
    chk("access_cycles", 64'(n_acc), 64'(exp_acc));
    chk("apb_protocol", 64'(viol), 64'(0));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));

    hviol = 0;
    if (hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        @(negedge pclk);
        if (!bus.rsp_valid || bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_err ||
            bus.rsp_timeout !== exp_to || bus.cmd_ready || bus.psel != '0) hviol++;
      end
      bus.rsp_ready = 1'b1;
    end
    chk("rsp_hold", 64'(hviol), 64'(0));
    @(negedge pclk);
    chk("rsp_drop_ready", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
    bus.rsp_ready = 1'b0;
    bus.pready = '0;
  endtask

  // Reset pulsed during ACCESS: outputs clear without waiting for a clock
  // edge and the aborted command never produces a response.
  task automatic reset_mid();
    int budget, viol;
    @(negedge pclk);
    bus.pready = '0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0040;
    bus.cmd_wdata = 32'h0; bus.cmd_strb = 4'h0;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    budget = 0;
    while (!bus.penable && budget < 10) begin
      @(negedge pclk);
      budget++;
    end
    chk("rst_reach_access", 64'(bus.penable), 64'(1));
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1 chk("rst_async_outs", 64'(any_out()), 64'(0));
    @(negedge pclk);
    chk("rst_held_outs", 64'(any_out()), 64'(0));
    presetn = 1'b1;
    viol = 0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      if (bus.rsp_valid || bus.psel != '0) viol++;
    end
    chk("rst_no_response", 64'(viol), 64'(0));
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    int rw;
    presetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_strb = '0;    bus.rsp_ready = 1'b0;
    bus.prdata = '0;      bus.pready = '0;      bus.pslverr = '0;
    repeat (2) @(negedge pclk);
    chk("reset_outs", 64'(any_out()), 64'(0));
    presetn = 1'b1;
    @(negedge pclk);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // write slave 1, zero wait
    run_txn(1'b1, 32'h4000_0010, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0, 0);
    // read slave 2 with three wait states
    run_txn(1'b0, 32'h8000_0020, 32'h1111_2222, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0);
    // read with pslverr
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h3, 1, 1'b1, 32'h1234_5678, 0);
    // slave never answers, then a normal command
    run_txn(1'b0, 32'h4000_0100, 32'h0, 4'h0, 1000, 1'b0, 32'h5555_AAAA, 0);
    run_txn(1'b0, 32'h4000_0104, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 0);
    // exactly one short of the timeout still completes
    run_txn(1'b1, 32'h0000_0008, 32'hCAFE_0001, 4'h5, TIMEOUT - 1, 1'b0, 32'h0, 0);
    // decode error on the unpopulated index
    run_txn(1'b1, 32'hC000_0000, 32'h7777_7777, 4'hF, 0, 1'b0, 32'h0, 0);
    // response back-pressure
    run_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 2, 1'b0, 32'h600D_CAFE, 5);
    reset_mid();

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 24)) : int'($urandom_range(0, 5));
      run_txn(1'($urandom), ra, $urandom, 4'($urandom), rw,
              ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
